// File: rtl/chained_bank_input_controller.sv
// chained_bank_input_controller: packs serial words into wide words and
// fills a ping-pong bank pair while the idle bank is served to the array.
module chained_bank_input_controller #(
  parameter int DATA_WIDTH  = 16,
  parameter int CHAIN_LEN   = 4,
  parameter int MEM_DEPTH   = 256,
  parameter int ADDR_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            soft_clear,
  input  logic                            config_en,
  input  logic [ADDR_WIDTH:0]             config_bank_depth,
  input  logic [COUNT_WIDTH-1:0]          config_num_banks,
  input  logic [DATA_WIDTH-1:0]           input_dat,
  input  logic                            input_vld,
  output logic                            input_rdy,
  input  logic                            ready_to_switch,
  input  logic                            ren,
  input  logic [ADDR_WIDTH-1:0]           raddr,
  output logic [DATA_WIDTH*CHAIN_LEN-1:0] rdata,
  output logic                            write_bank_ready,
  output logic [COUNT_WIDTH-1:0]          bank_count,
  output logic                            all_done
);

  localparam int WW = DATA_WIDTH * CHAIN_LEN;
  localparam int LW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [ADDR_WIDTH:0] MAX_DEPTH =
    (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_DEPTH =
    (ADDR_WIDTH+1)'(1);
  localparam logic [LW-1:0] LAST_LANE = LW'(CHAIN_LEN-1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE =
    COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WAIT_SW,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [LW-1:0]           lane_q, lane_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [COUNT_WIDTH-1:0]  bank_count_q, bank_count_d;
  logic                    wsel_q, wsel_d;
  logic [ADDR_WIDTH:0]     depth_q, depth_d;
  logic [COUNT_WIDTH-1:0]  num_banks_q, num_banks_d;
  logic [WW-1:0]           pack_q, pack_d;
  logic [WW-1:0]           rdata_q, rdata_d;
  logic                    mem_we;

  logic [WW-1:0] mem_q [2][MEM_DEPTH];

  assign rdata      = rdata_q;
  assign bank_count = bank_count_q;

  always_comb begin
    state_d          = state_q;
    lane_d           = lane_q;
    waddr_d          = waddr_q;
    bank_count_d     = bank_count_q;
    wsel_d           = wsel_q;
    depth_d          = depth_q;
    num_banks_d      = num_banks_q;
    pack_d           = pack_q;
    mem_we           = 1'b0;
    input_rdy        = 1'b0;
    write_bank_ready = 1'b0;
    all_done         = 1'b0;
    // read bank is always the one not being written
    rdata_d = ren ? mem_q[~wsel_q][raddr] : rdata_q;

    unique case (state_q)
      IDLE: begin
        if (config_en) begin
          if (config_bank_depth == '0)
            depth_d = ONE_DEPTH;
          else if (config_bank_depth > MAX_DEPTH)
            depth_d = MAX_DEPTH;
          else
            depth_d = config_bank_depth;
          num_banks_d = (config_num_banks == '0) ?
            CNT_ONE : config_num_banks;
          state_d = FILL;
        end
      end
      FILL: begin
        input_rdy = 1'b1;
        if (input_vld) begin
          pack_d[int'(lane_q)*DATA_WIDTH +: DATA_WIDTH] =
            input_dat;
          if (lane_q == LAST_LANE) begin
            lane_d = '0;
            mem_we = 1'b1;
            if ({1'b0, waddr_q} + 1'b1 == depth_q) begin
              waddr_d = '0;
              state_d = WAIT_SW;
              if (bank_count_q != CNT_MAX)
                bank_count_d = bank_count_q + 1'b1;
            end else begin
              waddr_d = waddr_q + 1'b1;
            end
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      WAIT_SW: begin
        write_bank_ready = 1'b1;
        if (ready_to_switch) begin
          wsel_d  = ~wsel_q;
          state_d = (bank_count_q == num_banks_q) ?
            DONE : FILL;
        end
      end
      DONE: begin
        all_done = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (soft_clear) begin
      state_d      = IDLE;
      lane_d       = '0;
      waddr_d      = '0;
      bank_count_d = '0;
      wsel_d       = 1'b0;
      mem_we       = 1'b0;
      rdata_d      = rdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lane_q       <= '0;
      waddr_q      <= '0;
      bank_count_q <= '0;
      wsel_q       <= 1'b0;
      depth_q      <= ONE_DEPTH;
      num_banks_q  <= CNT_ONE;
      pack_q       <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      waddr_q      <= waddr_d;
      bank_count_q <= bank_count_d;
      wsel_q       <= wsel_d;
      depth_q      <= depth_d;
      num_banks_q  <= num_banks_d;
      pack_q       <= pack_d;
      rdata_q      <= rdata_d;
    end
  end

  // the last lane is written straight from the live input word
  always_ff @(posedge clk) begin
    if (rst_n && mem_we)
      mem_q[wsel_q][waddr_q] <= pack_d;
  end

endmodule
